// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the counter control front-end: width helper and FSM state encoding.
package count_ctrl_pkg;

   // Bits needed to hold the given value; never less than one.
   function automatic int clogb2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((value >> i) != 0) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_STEP  = 3'd2;
   localparam logic [2:0] ST_LOAD1 = 3'd3;
   localparam logic [2:0] ST_LOAD2 = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      STEP  = ST_STEP,
      LOAD1 = ST_LOAD1,
      LOAD2 = ST_LOAD2
   } ctrl_state_t;

endpackage

// File: rtl/count_ctrl_frontend_if.sv
// Link between the control front-end (master) and the mod-M counter it drives (slave).
interface count_ctrl_frontend_if
   import count_ctrl_pkg::*;
#(
   parameter int M = 10
);
   localparam int N = clogb2(M - 1);

   logic         enable;
   logic         aload;
   logic [N-1:0] data;
   logic         rollover_in;

   modport master (output enable, output aload, output data, input rollover_in);
   modport slave  (input enable, input aload, input data, output rollover_in);

endinterface

// File: rtl/count_ctrl_frontend_btn_cond.sv
// Button conditioning: 2-flop synchroniser, debounce filter when COUNT_CTRL_DEBOUNCE_EN
// is defined, then a registered rising-edge detector giving a one-cycle pulse.
module btn_cond
   import count_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic aclr,
   input  logic btn,
   output logic pulse
);

`ifdef COUNT_CTRL_DEBOUNCE_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif

   logic sync_p0, sync_p1;
   logic lvl;
   logic prev_p2, pulse_p2;

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
      end
   end

   generate
      if (DB_EN && DB_CYCLES > 0) begin : g_db
         localparam int DBW = clogb2(DB_CYCLES);
         logic [DBW-1:0] db_cnt;
         logic           db_lvl;

         // Any sample agreeing with the filtered level restarts the stability window.
         always_ff @(posedge clk or negedge aclr) begin
            if (!aclr) begin
               db_cnt <= '0;
               db_lvl <= 1'b0;
            end else if (sync_p1 == db_lvl) begin
               db_cnt <= '0;
            end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
               db_lvl <= sync_p1;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end

         assign lvl = db_lvl;
      end else begin : g_nodb
         assign lvl = sync_p1;
      end
   endgenerate

   // Edge-detect stage
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         prev_p2  <= 1'b0;
         pulse_p2 <= 1'b0;
      end else begin
         prev_p2  <= lvl;
         pulse_p2 <= lvl & ~prev_p2;
      end
   end

   assign pulse = pulse_p2;

endmodule

// File: rtl/count_ctrl_frontend.sv
// Control front-end for a mod-M counter: prescaled tick, run/pause/single-step FSM and
// glitch-free preset load. Define COUNT_CTRL_DEBOUNCE_EN to add button debounce filters.
module count_ctrl_frontend
   import count_ctrl_pkg::*;
#(
   parameter  int M         = 10,
   parameter  int CLK_HZ    = 50_000_000,
   parameter  int TICK_HZ   = 1,
   parameter  int DB_CYCLES = 500_000,
   localparam int N         = clogb2(M - 1)
) (
   input  logic                         clk,
   input  logic                         aclr,
   input  logic                         btn_run,
   input  logic                         btn_step,
   input  logic                         btn_load,
   input  logic [N-1:0]                 sw_data,
   input  logic                         one_shot,
   output logic                         running,
   count_ctrl_frontend_if.master        cnt
);

   localparam int             DIV      = CLK_HZ / TICK_HZ;
   localparam int             PW       = clogb2(DIV - 1);
   localparam logic [PW-1:0]  PC_LAST  = PW'(DIV - 1);
   localparam logic [N:0]     M_EXT    = (N + 1)'(M);
   localparam logic [N-1:0]   DATA_MAX = N'(M - 1);

   logic         run_p, step_p, load_p;
   logic [N-1:0] sw_p0, sw_p1;
   ctrl_state_t  state, state_nxt;
   logic [PW-1:0] pc;
   logic         enable_d, aload_d;
   logic         enable_q, aload_q;
   logic [N-1:0] data_q;

   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_run  (.clk(clk), .aclr(aclr), .btn(btn_run),  .pulse(run_p));
   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_step (.clk(clk), .aclr(aclr), .btn(btn_step), .pulse(step_p));
   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_load (.clk(clk), .aclr(aclr), .btn(btn_load), .pulse(load_p));

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         sw_p0 <= '0;
         sw_p1 <= '0;
      end else begin
         sw_p0 <= sw_data;
         sw_p1 <= sw_p0;
      end
   end

   // A tick is suppressed whenever RUN is being left on the same edge.
   always_comb begin
      state_nxt = state;
      enable_d  = 1'b0;
      aload_d   = 1'b0;
      unique case (state)
         IDLE: begin
            if (load_p)      state_nxt = LOAD1;
            else if (run_p)  state_nxt = RUN;
            else if (step_p) state_nxt = STEP;
         end
         RUN: begin
            if (load_p)                          state_nxt = LOAD1;
            else if (run_p)                      state_nxt = IDLE;
            else if (one_shot && cnt.rollover_in) state_nxt = IDLE;
            else                                 enable_d  = (pc == PC_LAST);
         end
         STEP: begin
            enable_d  = 1'b1;
            state_nxt = IDLE;
         end
         LOAD1: state_nxt = LOAD2;
         LOAD2: begin
            aload_d   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state    <= IDLE;
         pc       <= '0;
         enable_q <= 1'b0;
         aload_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         state    <= state_nxt;
         enable_q <= enable_d;
         aload_q  <= aload_d;
         if (state == RUN && state_nxt == RUN)
            pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
         else
            pc <= '0;
         // Preset settles during LOAD1, one cycle ahead of the aload strobe.
         if (state == LOAD1)
            data_q <= ({1'b0, sw_p1} >= M_EXT) ? DATA_MAX : sw_p1;
      end
   end

   assign running    = (state == RUN);
   assign cnt.enable = enable_q;
   assign cnt.aload  = aload_q;
   assign cnt.data   = data_q;

endmodule

// File: doc/count_ctrl_frontend.md
# count_ctrl_frontend

Control front-end for the mod-M rollover counters. It converts raw push-buttons and a switch bank into the counter's `enable`, `aload` and `data` inputs. It generates a prescaled one-cycle count tick, run/pause/single-step control, and a glitch-free preset load. It also optionally stops the run when the downstream counter reports rollover.

## Interface
Parameters:
- `M`, 10: modulus of the driven counter. `N = clogb2(M-1)` is a localparam.
- `CLK_HZ`, 50_000_000: `clk` frequency.
- `TICK_HZ`, 1: count rate. `DIV = CLK_HZ/TICK_HZ`, and `DIV` must be ≥ 2.
- `DB_CYCLES`, 500_000: debounce stability window in `clk` cycles. Used only when debounce is compiled in.

Ports:
- `clk`, in, 1: clock, rising edge.
- `aclr`, in, 1: asynchronous, active-low reset.
- `btn_run`, in, 1: raw button; a rising edge toggles run/pause.
- `btn_step`, in, 1: raw button; a rising edge issues one count while paused.
- `btn_load`, in, 1: raw button; a rising edge loads `sw_data`.
- `sw_data`, in, N: raw preset switches.
- `one_shot`, in, 1: level input, must be static. When 1, a rollover ends the run.
- `rollover_in`, in, 1: rollover flag from the driven counter.
- `enable`, out, 1: count enable; one-cycle pulses.
- `aload`, out, 1: load strobe to the counter.
- `data`, out, N: registered preset value.
- `running`, out, 1: high while in `RUN`.

## Operation
- Input conditioning for all three buttons: 2-flop synchroniser, optional debounce, then rising-edge detect. This produces one-cycle pulses `run_p`, `step_p` and `load_p`.
- `sw_data` passes through a 2-flop synchroniser with no debounce.
- FSM states: `IDLE`, `RUN`, `STEP`, `LOAD1`, `LOAD2`. Reset state is `IDLE`.
- Pulse priority when pulses coincide: `load_p` > `run_p` > `step_p`. Lower-priority pulses in the same cycle are dropped.
- `IDLE`:
  - `load_p` → `LOAD1`.
  - `run_p` → `RUN`.
  - `step_p` → `STEP`.
- `RUN`:
  - `load_p` → `LOAD1`.
  - `run_p` → `IDLE`.
  - `step_p` is ignored.
  - `one_shot && rollover_in` → `IDLE`.
- `STEP`: `enable`=1 for exactly one cycle, then → `IDLE`.
- `LOAD1`:
  - `data` <= synchronised `sw_data`, clamped to M-1 if the value is ≥ M.
  - `aload`=0 in this cycle, so `data` settles before the strobe.
  - → `LOAD2`.
- `LOAD2`: `aload`=1 for one cycle, then → `IDLE`. After a load the block is always paused.
- Prescaler:
  - Counter `pc` of width `clogb2(DIV-1)`.
  - Increments only in `RUN` and wraps from DIV-1 to 0.
  - Cleared to 0 on every entry to `RUN` and in every non-`RUN` state.
- In `RUN`, `enable` = (`pc == DIV-1`). All outputs are registered.
- `running` = (state == `RUN`).
- `data` holds its value between loads.
- `aload` and `enable` are never high in the same cycle.

## Timing
- Reset values (asynchronous on `aclr`=0): `enable`=0, `aload`=0, `data`=0, `running`=0, state `IDLE`, `pc`=0, synchroniser and edge flops 0.
- A button rising edge becomes a pulse 3 `clk` edges later without debounce: 2 synchroniser edges + 1 edge-detect edge.
- Pulse to response:
  - `STEP`: `enable` high 2 cycles after the pulse.
  - Load: `aload` high 3 cycles after the pulse, with `data` valid 1 cycle before `aload`.
  - Run: first `enable` DIV cycles after entering `RUN`.
  - Tick spacing is exactly DIV cycles.
- One-shot stop: `rollover_in` sampled high in `RUN` gives `IDLE` on the next edge. No `enable` is issued in that next cycle.
- `aclr` asserted mid-`LOAD`/`STEP`: outputs drop to 0 immediately. No partial strobe completes after release.
- A button held high produces exactly one pulse.

## Configuration
- `COUNT_CTRL_DEBOUNCE_EN` defined:
  - Each synchronised button level passes through a filter.
  - The filtered level changes only after the raw level has differed from it for DB_CYCLES consecutive cycles.
  - Any bounce restarts the window.
  - Pulse latency becomes 3 + DB_CYCLES cycles.
- Not defined: the filter is absent, and the synchroniser output feeds edge-detect directly.

## Structure
- Shared package `count_ctrl_pkg` contains:
  - the `clogb2` function;
  - the state enum `ctrl_state_t`;
  - localparams for the state encodings.
- One sub-module, `btn_cond`: synchroniser, optional debounce and edge detect, with one-cycle pulse output. It is instantiated 3 times.
- Prescaler and FSM live in the top level.

## Test plan
Bench parameters: M=10, CLK_HZ=40, TICK_HZ=10 (DIV=4), DB_CYCLES=4.
- Reset: `aclr`=0 → `enable`/`aload`/`running`/`data` all 0. Release, then 20 idle cycles → all remain 0.
- Run: `btn_run` rising edge → `running`=1. `enable` pulses on every 4th cycle; 10 pulses in 40 cycles. A second `btn_run` edge → `running`=0 and no further pulses.
- Step: `btn_step` held 50 cycles while paused → exactly one `enable` pulse. The same button while running → no extra pulse.
- Load with clamp:
  - `sw_data`=7, `btn_load` → `data`=7, then `aload` high one cycle later for exactly 1 cycle, and `running`=0.
  - `sw_data`=13 → `data`=9.
- Priority and one-shot:
  - `btn_load` and `btn_run` edges in the same cycle while in `IDLE` → load only, `running` stays 0.
  - `one_shot`=1, running, `rollover_in` pulsed → `running`=0 on the next edge and no further `enable`.
- Debounce (with `COUNT_CTRL_DEBOUNCE_EN`): `btn_step` toggling every 2 cycles for 20 cycles, then held high → exactly one `enable`, issued 4+ cycles after the level becomes stable.
